// File: rtl/instruction_fetch_stage.sv
// RV32 instruction fetch stage: PC register, 1-cycle synchronous imem interface,
// a one-entry capture buffer for read data landing during a stall, and the IF/ID register.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 10,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   imem_en,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            id_instruction,
  output logic [31:0]            id_pc,
  output logic                   id_valid
);

  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_AL   = RESET_PC & PC_ALIGN_MASK;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_STALL    = 2'd1,
    MODE_REDIRECT = 2'd2
  } mode_t;

  logic [31:0] r_pc_f;
  logic        r_req_valid;
  logic [31:0] r_req_pc;
  logic        r_buf_valid;
  logic [31:0] r_buf_data;
  logic [31:0] r_id_instruction;
  logic [31:0] r_id_pc;
  logic        r_id_valid;

  mode_t       w_mode;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_f_nxt;
  logic        w_req_valid_nxt;
  logic [31:0] w_req_pc_nxt;
  logic        w_buf_valid_nxt;
  logic [31:0] w_buf_data_nxt;
  logic [31:0] w_id_instruction_nxt;
  logic [31:0] w_id_pc_nxt;
  logic        w_id_valid_nxt;

  assign w_redirect_pc = redirect_pc & PC_ALIGN_MASK;

  // A redirect kills the fetch even when decode is stalled, so it outranks stall.
  always_comb begin
    w_mode = MODE_RUN;
    if (redirect_valid) begin
      w_mode = MODE_REDIRECT;
    end else if (stall) begin
      w_mode = MODE_STALL;
    end else begin
      w_mode = MODE_RUN;
    end
  end

  assign imem_en   = ~reset & ~stall & ~redirect_valid;
  assign imem_addr = r_pc_f[IMEM_ADDR_W+1:2];

  // Next-state for PC, in-flight request, capture buffer and IF/ID register.
  always_comb begin
    w_pc_f_nxt           = r_pc_f;
    w_req_valid_nxt      = r_req_valid;
    w_req_pc_nxt         = r_req_pc;
    w_buf_valid_nxt      = r_buf_valid;
    w_buf_data_nxt       = r_buf_data;
    w_id_instruction_nxt = r_id_instruction;
    w_id_pc_nxt          = r_id_pc;
    w_id_valid_nxt       = r_id_valid;
    case (w_mode)
      MODE_REDIRECT: begin
        w_pc_f_nxt           = w_redirect_pc;
        w_req_valid_nxt      = 1'b0;
        w_buf_valid_nxt      = 1'b0;
        w_id_valid_nxt       = 1'b0;
        w_id_instruction_nxt = NOP_INSTR;
      end
      MODE_STALL: begin
        // Read data is only on the bus for the first stalled cycle; keep it.
        if (r_req_valid && !r_buf_valid) begin
          w_buf_valid_nxt = 1'b1;
          w_buf_data_nxt  = imem_rdata;
        end else begin
          w_buf_valid_nxt = r_buf_valid;
          w_buf_data_nxt  = r_buf_data;
        end
      end
      MODE_RUN: begin
        if (r_buf_valid) begin
          w_id_instruction_nxt = r_buf_data;
        end else if (r_req_valid) begin
          w_id_instruction_nxt = imem_rdata;
        end else begin
          w_id_instruction_nxt = NOP_INSTR;
        end
        w_id_pc_nxt     = r_req_pc;
        w_id_valid_nxt  = r_req_valid;
        w_buf_valid_nxt = 1'b0;
        w_req_valid_nxt = 1'b1;
        w_req_pc_nxt    = r_pc_f;
        w_pc_f_nxt      = r_pc_f + 32'd4;
      end
      default: begin
        w_pc_f_nxt           = RESET_PC_AL;
        w_req_valid_nxt      = 1'b0;
        w_buf_valid_nxt      = 1'b0;
        w_id_valid_nxt       = 1'b0;
        w_id_instruction_nxt = NOP_INSTR;
      end
    endcase
  end

  // Fetch-side state: PC, outstanding request and capture buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_f      <= RESET_PC_AL;
      r_req_valid <= 1'b0;
      r_req_pc    <= 32'd0;
      r_buf_valid <= 1'b0;
      r_buf_data  <= 32'd0;
    end else begin
      r_pc_f      <= w_pc_f_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_req_pc    <= w_req_pc_nxt;
      r_buf_valid <= w_buf_valid_nxt;
      r_buf_data  <= w_buf_data_nxt;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id_instruction <= NOP_INSTR;
      r_id_pc          <= 32'd0;
      r_id_valid       <= 1'b0;
    end else begin
      r_id_instruction <= w_id_instruction_nxt;
      r_id_pc          <= w_id_pc_nxt;
      r_id_valid       <= w_id_valid_nxt;
    end
  end

  assign id_instruction = r_id_instruction;
  assign id_pc          = r_id_pc;
  assign id_valid       = r_id_valid;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed scenarios with literal
// expectations plus randomized stall/redirect/reset traffic against a PC-stream model.
module tb_instruction_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic        id_valid;

  logic        imem_en2;
  logic [9:0]  imem_addr2;
  logic [31:0] imem_rdata2 = 32'd0;
  logic [31:0] id_instruction2;
  logic [31:0] id_pc2;
  logic        id_valid2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instruction_fetch_stage #(
    .RESET_PC(32'h0000_0000), .IMEM_ADDR_W(10), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .id_instruction(id_instruction), .id_pc(id_pc),
    .id_valid(id_valid)
  );

  instruction_fetch_stage #(
    .RESET_PC(32'hFFFF_FFF8), .IMEM_ADDR_W(10), .NOP_INSTR(NOP)
  ) dut_wrap (
    .clk(clk), .reset(reset), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_pc(32'd0), .imem_en(imem_en2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .id_instruction(id_instruction2), .id_pc(id_pc2),
    .id_valid(id_valid2)
  );

  // Instruction memory contents: word i holds 0x1000_0000 + i.
  function automatic logic [31:0] word_at(input logic [31:0] byte_addr);
    return 32'h1000_0000 + {22'd0, byte_addr[11:2]};
  endfunction

  // Synchronous memories; output is garbage after any cycle without a read strobe.
  always @(posedge clk) begin
    imem_rdata  <= imem_en  ? (32'h1000_0000 + {22'd0, imem_addr})  : $urandom;
    imem_rdata2 <= imem_en2 ? (32'h1000_0000 + {22'd0, imem_addr2}) : $urandom;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stream of fetched PCs, tracked as a queue of issued
  // addresses still owed to decode, plus what decode currently holds.
  logic [31:0] m_npc = 32'd0;
  logic [31:0] m_q[$];
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_instr = NOP;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_npc = 32'd0;
      m_q.delete();
      m_valid = 1'b0;
      m_pc = 32'd0;
      m_instr = NOP;
    end else if (redirect_valid) begin
      m_npc = {redirect_pc[31:2], 2'b00};
      m_q.delete();
      m_valid = 1'b0;
      m_instr = NOP;
    end else if (!stall) begin
      if (m_q.size() > 0) begin
        m_pc = m_q.pop_front();
        m_valid = 1'b1;
        m_instr = word_at(m_pc);
      end else begin
        m_valid = 1'b0;
        m_instr = NOP;
      end
      m_q.push_back(m_npc);
      m_npc = m_npc + 32'd4;
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_en", {31'd0, imem_en}, 32'd0);
      check("rst_valid", {31'd0, id_valid}, 32'd0);
      check("rst_instr", id_instruction, NOP);
      check("rst_pc", id_pc, 32'd0);
    end else begin
      check("m_valid", {31'd0, id_valid}, {31'd0, m_valid});
      check("m_instr", id_instruction, m_instr);
      if (m_valid) check("m_pc", id_pc, m_pc);
      check("m_en", {31'd0, imem_en}, {31'd0, !stall && !redirect_valid});
      if (imem_en) check("m_addr", {22'd0, imem_addr}, {22'd0, m_npc[11:2]});
    end
  end

  // Apply inputs for one rising edge and return 2 time units after the next falling edge.
  task automatic cyc(input logic s, input logic r, input logic [31:0] rpc);
    stall = s;
    redirect_valid = r;
    redirect_pc = rpc;
    @(negedge clk);
    #2;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;

    // Reset release and first instructions.
    cyc(1'b0, 1'b0, 32'd0);
    check("first_edge_invalid", {31'd0, id_valid}, 32'd0);
    cyc(1'b0, 1'b0, 32'd0);
    check("first_valid", {31'd0, id_valid}, 32'd1);
    check("first_pc", id_pc, 32'h0);
    check("first_instr", id_instruction, 32'h1000_0000);
    check("wrap_pc0", id_pc2, 32'hFFFF_FFF8);
    check("wrap_instr0", id_instruction2, 32'h1000_03FE);
    cyc(1'b0, 1'b0, 32'd0);
    check("seq_pc4", id_pc, 32'h4);
    check("wrap_pc1", id_pc2, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'd0);
    check("seq_pc8", id_pc, 32'h8);
    check("wrap_pc2", id_pc2, 32'h0000_0000);
    check("wrap_instr2", id_instruction2, 32'h1000_0000);

    // Three-cycle stall holding pc 8.
    stall = 1'b1;
    #1;
    check("stall_en", {31'd0, imem_en}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 32'd0);
      check("stall_hold_pc", id_pc, 32'h8);
      check("stall_hold_instr", id_instruction, 32'h1000_0002);
      if (i == 0) check("wrap_pc3", id_pc2, 32'h0000_0004);
    end
    cyc(1'b0, 1'b0, 32'd0);
    check("post_stall_pc", id_pc, 32'hC);
    check("post_stall_buf_instr", id_instruction, 32'h1000_0003);
    cyc(1'b0, 1'b0, 32'd0);
    check("post_stall_pc16", id_pc, 32'h10);

    // Redirect to an unaligned target.
    cyc(1'b0, 1'b1, 32'h0000_0102);
    check("redir_valid", {31'd0, id_valid}, 32'd0);
    check("redir_nop", id_instruction, NOP);
    check("redir_addr", {22'd0, imem_addr}, 32'h40);
    cyc(1'b0, 1'b0, 32'd0);
    check("redir_gap", {31'd0, id_valid}, 32'd0);
    cyc(1'b0, 1'b0, 32'd0);
    check("redir_pc", id_pc, 32'h100);
    check("redir_instr", id_instruction, 32'h1000_0040);

    // Redirect and stall together, then stall alone.
    cyc(1'b1, 1'b1, 32'h0000_0200);
    check("rs_valid", {31'd0, id_valid}, 32'd0);
    cyc(1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 32'd0);
    check("rs_still_invalid", {31'd0, id_valid}, 32'd0);
    cyc(1'b0, 1'b0, 32'd0);
    check("rs_resume_gap", {31'd0, id_valid}, 32'd0);
    cyc(1'b0, 1'b0, 32'd0);
    check("rs_target_pc", id_pc, 32'h200);
    check("rs_target_instr", id_instruction, 32'h1000_0080);

    // Asynchronous reset in the middle of a stall with the buffer full.
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 32'd0);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, id_valid}, 32'd0);
    check("async_rst_en", {31'd0, imem_en}, 32'd0);
    check("async_rst_instr", id_instruction, NOP);
    @(negedge clk);
    #2;
    reset = 1'b0;
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0);
    check("rerst_pc", id_pc, 32'h0);
    check("rerst_instr", id_instruction, 32'h1000_0000);
    cyc(1'b0, 1'b0, 32'd0);
    check("rerst_instr1", id_instruction, 32'h1000_0001);

    // Randomized traffic checked by the model.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, $urandom);
    end
    reset = 1'b0;
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
